// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: synchroniser, counter debounce, press/release pulses, long-press detect.
// Optional auto-repeat in HELD is compiled in with `define BTN_AUTO_REPEAT_EN; otherwise btn_repeat is tied low.
module btn_conditioner #(
   parameter int N_BTN           = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 100000000,
   parameter int REPEAT_CYCLES   = 20000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_rise,
   output logic [N_BTN-1:0] btn_fall,
   output logic [N_BTN-1:0] btn_long,
   output logic [N_BTN-1:0] btn_repeat
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   typedef enum logic [1:0] {RELEASED, PRESSED, HELD} st_t;

   generate
      if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
         $error("btn_conditioner: illegal parameter combination");
      end
   endgenerate

   genvar i;
   generate
      for (i = 0; i < N_BTN; i++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   s;
         logic [DW-1:0]          deb_cnt_q;
         logic                   level_q;
         logic                   toggle;
         logic                   press_acc;
         logic                   release_acc;
         logic                   rise_q;
         logic                   fall_q;
         st_t                    state_q, state_d;
         logic [HW-1:0]          hold_q, hold_d;
         logic                   long_d, long_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            end
         end

         assign s           = sync_q[SYNC_STAGES-1];
         assign toggle      = (s != level_q) && (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
         assign press_acc   = toggle && s;
         assign release_acc = toggle && !s;

         // Counter only runs while the synchronised input disagrees with the accepted level.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               deb_cnt_q <= '0;
               level_q   <= 1'b0;
               rise_q    <= 1'b0;
               fall_q    <= 1'b0;
            end else begin
               rise_q <= press_acc;
               fall_q <= release_acc;
               if (s == level_q) begin
                  deb_cnt_q <= '0;
               end else if (toggle) begin
                  deb_cnt_q <= '0;
                  level_q   <= ~level_q;
               end else begin
                  deb_cnt_q <= deb_cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= RELEASED;
               hold_q  <= '0;
               long_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               hold_q  <= hold_d;
               long_q  <= long_d;
            end
         end

         // Release is checked first so a fall can never coincide with a long pulse.
         always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            long_d  = 1'b0;
            case (state_q)
               RELEASED: begin
                  if (press_acc) begin
                     state_d = PRESSED;
                     hold_d  = '0;
                  end
               end
               PRESSED: begin
                  if (release_acc) begin
                     state_d = RELEASED;
                  end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
                     long_d  = 1'b1;
                     state_d = HELD;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
               HELD: begin
                  if (release_acc) begin
                     state_d = RELEASED;
                  end
               end
               default: state_d = RELEASED;
            endcase
         end

         assign btn_level[i] = level_q;
         assign btn_rise[i]  = rise_q;
         assign btn_fall[i]  = fall_q;
         assign btn_long[i]  = long_q;

`ifdef BTN_AUTO_REPEAT_EN
         localparam int RW = $clog2(REPEAT_CYCLES + 1);
         logic [RW-1:0] rep_cnt_q;
         logic          rep_q;

         // Counter starts from zero on entry to HELD, so the first pulse lands one full period after btn_long.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rep_cnt_q <= '0;
               rep_q     <= 1'b0;
            end else begin
               rep_q <= 1'b0;
               if (state_q == HELD && !release_acc) begin
                  if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                     rep_cnt_q <= '0;
                     rep_q     <= 1'b1;
                  end else begin
                     rep_cnt_q <= rep_cnt_q + 1'b1;
                  end
               end else begin
                  rep_cnt_q <= '0;
               end
            end
         end

         assign btn_repeat[i] = rep_q;
`else
         assign btn_repeat[i] = 1'b0;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner against a sliding-window behavioural model.
module tb_btn_conditioner;
   localparam int N = 2;
   localparam int S = 2;
   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_level, btn_rise, btn_fall, btn_long, btn_repeat;

   btn_conditioner #(
      .N_BTN(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
      .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
      .btn_long(btn_long), .btn_repeat(btn_repeat)
   );

   always #5 clk = ~clk;

   // model: input delay line, last D synchronised samples, and time since accepted press
   logic [S-1:0] m_sync [N];
   logic         m_win  [N][D];
   logic [N-1:0] m_level;
   logic [N-1:0] e_level, e_rise, e_fall, e_long, e_rep;
   int           cyc = 0;
   int           rise_t [N];

   int n_cmp = 0;
   int n_bad = 0;

   int cnt_rise [N], cnt_fall [N], cnt_long [N], cnt_rep [N];
   int rise_cyc [N], fall_cyc [N], long_cyc [N], rep1_cyc [N];

   task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N; c++) begin
         m_sync[c] = '0;
         for (int j = 0; j < D; j++) m_win[c][j] = 1'b0;
         rise_t[c] = 0;
      end
      m_level = '0;
      e_level = '0; e_rise = '0; e_fall = '0; e_long = '0; e_rep = '0;
   endtask

   task automatic model_step();
      logic s, old, all_diff;
      int   held;
      cyc++;
      for (int c = 0; c < N; c++) begin
         s = m_sync[c][S-1];
         m_sync[c] = {m_sync[c][S-2:0], btn_in[c]};
         for (int j = D - 1; j > 0; j--) m_win[c][j] = m_win[c][j-1];
         m_win[c][0] = s;
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) if (m_win[c][j] == m_level[c]) all_diff = 1'b0;
         old = m_level[c];
         if (all_diff) m_level[c] = ~old;
         e_level[c] = m_level[c];
         e_rise[c]  = m_level[c] && !old;
         e_fall[c]  = !m_level[c] && old;
         if (e_rise[c]) rise_t[c] = cyc;
         held = cyc - rise_t[c];
         e_long[c] = m_level[c] && !e_rise[c] && (held == L);
`ifdef BTN_AUTO_REPEAT_EN
         e_rep[c] = m_level[c] && (held > L) && ((held - L) % R == 0);
`else
         e_rep[c] = 1'b0;
`endif
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < N; c++) begin
         cnt_rise[c] = 0; cnt_fall[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
         rise_cyc[c] = -1; fall_cyc[c] = -1; long_cyc[c] = -1; rep1_cyc[c] = -1;
      end
   endtask

   // called at a negedge with inputs already set; returns at the next negedge
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk_vec("level",  btn_level,  e_level);
      chk_vec("rise",   btn_rise,   e_rise);
      chk_vec("fall",   btn_fall,   e_fall);
      chk_vec("long",   btn_long,   e_long);
      chk_vec("repeat", btn_repeat, e_rep);
      for (int c = 0; c < N; c++) begin
         if (btn_rise[c]) begin cnt_rise[c]++; rise_cyc[c] = cyc; end
         if (btn_fall[c]) begin cnt_fall[c]++; fall_cyc[c] = cyc; end
         if (btn_long[c]) begin cnt_long[c]++; long_cyc[c] = cyc; end
         if (btn_repeat[c]) begin
            if (cnt_rep[c] == 0) rep1_cyc[c] = cyc;
            cnt_rep[c]++;
         end
      end
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic async_reset();
      rst_n = 1'b0;
      #1;
      chk_vec("rst_level", btn_level, '0);
      chk_vec("rst_rise",  btn_rise,  '0);
      chk_vec("rst_fall",  btn_fall,  '0);
      chk_vec("rst_long",  btn_long,  '0);
      chk_vec("rst_rep",   btn_repeat, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit fast;
      model_reset();
      clear_stats();

      // reset with both buttons pressed
      btn_in = 2'b11;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      chk_vec("rst_hold_level", btn_level, 2'b00);
      chk_vec("rst_hold_rise",  btn_rise,  2'b00);
      rst_n = 1'b1;
      ticks(7);
      chk_vec("post_rst_level", btn_level, 2'b11);
      chk_int("post_rst_rise0", cnt_rise[0], 1);
      chk_int("post_rst_rise1", cnt_rise[1], 1);
      btn_in = 2'b00;
      ticks(8);

      // bounce shorter than debounce window
      clear_stats();
      btn_in[0] = 1'b1; ticks(3);
      btn_in[0] = 1'b0; ticks(10);
      chk_int("bounce_rise", cnt_rise[0], 0);
      chk_int("bounce_fall", cnt_fall[0], 0);

      // clean press/release on channel 0
      clear_stats();
      btn_in[0] = 1'b1; ticks(10);
      btn_in[0] = 1'b0; ticks(12);
      chk_int("clean_rise0", cnt_rise[0], 1);
      chk_int("clean_fall0", cnt_fall[0], 1);
      chk_int("clean_width", fall_cyc[0] - rise_cyc[0], 10);
      chk_int("clean_rise1", cnt_rise[1], 0);

      // long press on channel 1
      clear_stats();
      btn_in[1] = 1'b1; ticks(40);
      btn_in[1] = 1'b0; ticks(12);
      chk_int("long_count", cnt_long[1], 1);
      chk_int("long_delay", long_cyc[1] - rise_cyc[1], 20);
      chk_int("long_fall",  cnt_fall[1], 1);
`ifdef BTN_AUTO_REPEAT_EN
      chk_int("rep_count", cnt_rep[1], 3);
      chk_int("rep_first", rep1_cyc[1] - long_cyc[1], 5);
`else
      chk_int("rep_count", cnt_rep[1], 0);
`endif

      // release lands exactly on the long-press cycle
      clear_stats();
      btn_in[1] = 1'b1; ticks(20);
      btn_in[1] = 1'b0; ticks(12);
      chk_int("thr_long", cnt_long[1], 0);
      chk_int("thr_fall", cnt_fall[1], 1);
      chk_int("thr_width", fall_cyc[1] - rise_cyc[1], 20);

      // async reset while HELD, button kept down
      clear_stats();
      btn_in[1] = 1'b1; ticks(30);
      chk_int("held_long", cnt_long[1], 1);
      async_reset();
      clear_stats();
      ticks(40);
      chk_int("rearm_rise", cnt_rise[1], 1);
      chk_int("rearm_long_delay", long_cyc[1] - rise_cyc[1], 20);
      btn_in = 2'b00;
      ticks(10);

      // random traffic alternating bouncy and slow phases, occasional reset
      for (int k = 0; k < 4000; k++) begin
         if (k % 200 == 0) fast = 1'($urandom_range(0, 1));
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, fast ? 2 : 40) == 0) btn_in[c] = ~btn_in[c];
         if ($urandom_range(0, 999) == 0) async_reset();
         else tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
